// File: rtl/bcd_score_accumulator.sv
// BCD score accumulator: queues per-channel scoring events and adds their BCD point values one digit per cycle.
// Latency: NUM_DIGITS+2 cycles from the edge that sets a pending bit to the final score (1 select, NUM_DIGITS add, 1 finish).
// Backpressure: none; events wait in pending bits, and a repeat edge on an already-pending channel merges into it.
module bcd_score_accumulator #(
  parameter int NUM_DIGITS = 6,
  parameter int NUM_EVENTS = 6,
  parameter int VAL_DIGITS = 4,
  parameter int SATURATE   = 1,
  parameter int LIFE_DIGIT = 4
) (
  input  logic                               clk,
  input  logic                               resetN,
  input  logic [NUM_EVENTS-1:0]              evt_level,
  input  logic [NUM_EVENTS*VAL_DIGITS*4-1:0] points_bcd,
  input  logic                               clear_score,
  output logic [NUM_DIGITS*4-1:0]            score_bcd,
  output logic [NUM_DIGITS*4-1:0]            hiscore_bcd,
  output logic                               busy,
  output logic                               extra_life,
  output logic                               overflow
);

  localparam int SW = NUM_DIGITS * 4;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int EW = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_FIN} state_t;

  state_t                r_state;
  logic [NUM_EVENTS-1:0] r_evt_dly;
  logic [NUM_EVENTS-1:0] r_pending;
  logic [SW-1:0]         r_score;
  logic [SW-1:0]         r_hiscore;
  logic [SW-1:0]         r_val;
  logic [IW-1:0]         r_idx;
  logic                  r_carry;
  logic                  r_armed;
  logic                  r_overflow;
  logic                  r_extra_life;

  logic [NUM_EVENTS-1:0] w_rise;
  logic                  w_sel_vld;
  logic [EW-1:0]         w_sel_idx;
  logic [NUM_EVENTS-1:0] w_sel_mask;
  logic [NUM_EVENTS-1:0] w_pend_next;
  logic [SW-1:0]         w_cap_val;
  logic [3:0]            w_sdig;
  logic [3:0]            w_vdig;
  logic [4:0]            w_sum;
  logic [3:0]            w_wr_dig;
  logic                  w_cout;
  logic [SW-1:0]         w_final;
  logic                  w_life_hit;

  assign w_rise = evt_level & ~r_evt_dly;

  // Lowest-index pending channel wins: scan downward so the last hit is the lowest.
  always_comb begin
    w_sel_vld = 1'b0;
    w_sel_idx = '0;
    for (int k = NUM_EVENTS - 1; k >= 0; k--) begin
      if (r_pending[k]) begin
        w_sel_vld = 1'b1;
        w_sel_idx = EW'(k);
      end
    end
  end

  assign w_sel_mask  = (r_state == S_IDLE && w_sel_vld) ? (NUM_EVENTS'(1) << w_sel_idx) : '0;
  // A fresh edge on the channel being selected re-sets its bit, so it is not lost.
  assign w_pend_next = (r_pending & ~w_sel_mask) | w_rise;

  // Capture the selected channel's value, zero-extended to score width, bad nibbles clamped to 9.
  always_comb begin
    w_cap_val = '0;
    for (int d = 0; d < VAL_DIGITS; d++) begin
      w_cap_val[d*4 +: 4] = (points_bcd[(int'(w_sel_idx)*VAL_DIGITS + d)*4 +: 4] > 4'd9) ? 4'd9
                          : points_bcd[(int'(w_sel_idx)*VAL_DIGITS + d)*4 +: 4];
    end
  end

  // Single-digit BCD add with carry for the digit currently indexed.
  assign w_sdig   = r_score[r_idx*4 +: 4];
  assign w_vdig   = r_val[r_idx*4 +: 4];
  assign w_sum    = {1'b0, w_sdig} + {1'b0, w_vdig} + {4'b0, r_carry};
  assign w_cout   = (w_sum > 5'd9);
  assign w_wr_dig = w_cout ? 4'(w_sum - 5'd10) : w_sum[3:0];

  // Score as it will stand after the finish step; valid BCD compares correctly as plain binary.
  assign w_final    = (r_carry && SATURATE != 0) ? {NUM_DIGITS{4'h9}} : r_score;
  assign w_life_hit = |(w_final >> (LIFE_DIGIT * 4));

  // Edge-detect history; kept across new-game clears so held inputs are not recounted.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_evt_dly <= '0;
    else         r_evt_dly <= evt_level;
  end

  // Event queue and digit-serial add FSM; clear_score overrides everything except hiscore.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state      <= S_IDLE;
      r_pending    <= '0;
      r_score      <= '0;
      r_hiscore    <= '0;
      r_val        <= '0;
      r_idx        <= '0;
      r_carry      <= 1'b0;
      r_armed      <= 1'b1;
      r_overflow   <= 1'b0;
      r_extra_life <= 1'b0;
    end else if (clear_score) begin
      r_state      <= S_IDLE;
      r_pending    <= '0;
      r_score      <= '0;
      r_idx        <= '0;
      r_carry      <= 1'b0;
      r_armed      <= 1'b1;
      r_overflow   <= 1'b0;
      r_extra_life <= 1'b0;
    end else begin
      r_extra_life <= 1'b0;
      r_pending    <= w_pend_next;
      case (r_state)
        S_IDLE: begin
          if (w_sel_vld) begin
            r_val   <= w_cap_val;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          r_score[r_idx*4 +: 4] <= w_wr_dig;
          r_carry               <= w_cout;
          if (r_idx == IW'(NUM_DIGITS - 1)) r_state <= S_FIN;
          else                              r_idx   <= r_idx + 1'b1;
        end
        S_FIN: begin
          if (r_carry) r_overflow <= 1'b1;
          r_score <= w_final;
          if (w_final > r_hiscore) r_hiscore <= w_final;
          if (r_armed && w_life_hit) begin
            r_extra_life <= 1'b1;
            r_armed      <= 1'b0;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign score_bcd   = r_score;
  assign hiscore_bcd = r_hiscore;
  assign busy        = (r_state != S_IDLE) || (|r_pending);
  assign extra_life  = r_extra_life;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_bcd_score_accumulator.sv
// Directed bench for bcd_score_accumulator: default instance plus saturating and wrapping wide-value instances.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
module tb_bcd_score_accumulator;

  logic        clk = 1'b0;
  logic        resetN;
  logic [5:0]  evt;
  logic [95:0] pts;
  logic        clr;
  logic [23:0] score, hiscore;
  logic        busy, xl, ov;

  logic        evt2;
  logic [23:0] pts2;
  logic        clr2;
  logic [23:0] s_sc, s_hi, w_sc, w_hi;
  logic        s_busy, s_xl, s_ov, w_busy, w_xl, w_ov;

  int total = 0;
  int bad   = 0;
  int n;

  always #5 clk = ~clk;

  bcd_score_accumulator u_dut (
    .clk(clk), .resetN(resetN), .evt_level(evt), .points_bcd(pts), .clear_score(clr),
    .score_bcd(score), .hiscore_bcd(hiscore), .busy(busy), .extra_life(xl), .overflow(ov)
  );

  bcd_score_accumulator #(.NUM_EVENTS(1), .VAL_DIGITS(6), .SATURATE(1)) u_sat (
    .clk(clk), .resetN(resetN), .evt_level(evt2), .points_bcd(pts2), .clear_score(clr2),
    .score_bcd(s_sc), .hiscore_bcd(s_hi), .busy(s_busy), .extra_life(s_xl), .overflow(s_ov)
  );

  bcd_score_accumulator #(.NUM_EVENTS(1), .VAL_DIGITS(6), .SATURATE(0)) u_wrap (
    .clk(clk), .resetN(resetN), .evt_level(evt2), .points_bcd(pts2), .clear_score(clr2),
    .score_bcd(w_sc), .hiscore_bcd(w_hi), .busy(w_busy), .extra_life(w_xl), .overflow(w_ov)
  );

  task automatic tick(input int cnt);
    repeat (cnt) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One-cycle pulse on a default-instance channel; returns just after the edge that sets pending.
  task automatic pulse(input int ch);
    evt[ch] = 1'b1;
    tick(1);
    evt[ch] = 1'b0;
  endtask

  initial begin
    resetN = 1'b0; evt = '0; pts = '0; clr = 1'b0;
    evt2 = 1'b0; pts2 = '0; clr2 = 1'b0;
    tick(2);
    chk("rst_score", score, 32'h0);
    chk("rst_hi", hiscore, 32'h0);
    chk("rst_busy", busy, 32'h0);
    chk("rst_xl", xl, 32'h0);
    chk("rst_ov", ov, 32'h0);
    chk("rst_sat_score", s_sc, 32'h0);
    resetN = 1'b1;
    tick(1);

    // Single event: busy for exactly 8 cycles, then 000010.
    pts[15:0] = 16'h0010;
    pulse(0);
    for (int i = 0; i < 8; i++) begin
      chk("single_busy_hi", busy, 32'h1);
      tick(1);
    end
    chk("single_busy_lo", busy, 32'h0);
    chk("single_score", score, 32'h000010);
    chk("single_hi", hiscore, 32'h000010);

    // Three simultaneous edges are served 0,1,2 in 8-cycle slots.
    clr = 1'b1; tick(1); clr = 1'b0;
    chk("clr_score", score, 32'h0);
    chk("clr_hi_kept", hiscore, 32'h000010);
    pts[31:16] = 16'h0050;
    pts[47:32] = 16'h0200;
    evt[2:0] = 3'b111; tick(1); evt = '0;
    tick(8);
    chk("multi_after_ch0", score, 32'h000010);
    tick(8);
    chk("multi_after_ch1", score, 32'h000060);
    tick(8);
    chk("multi_final", score, 32'h000260);
    chk("multi_busy_lo", busy, 32'h0);

    // Extra life on first reaching 10000, not again.
    clr = 1'b1; tick(1); clr = 1'b0;
    pts[63:48] = 16'h9990;
    pulse(3); tick(8);
    chk("life_pre_score", score, 32'h009990);
    pulse(0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (xl) n++;
    end
    chk("life_pulse_cnt", n, 32'd1);
    chk("life_score", score, 32'h010000);
    pulse(0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (xl) n++;
    end
    chk("life_no_repeat", n, 32'd0);
    chk("life_score2", score, 32'h010010);
    chk("life_ov", ov, 32'h0);

    // Reset while digit 2 is being added.
    pulse(0);
    tick(3);
    resetN = 1'b0;
    #1;
    chk("midadd_score", score, 32'h0);
    chk("midadd_hi", hiscore, 32'h0);
    chk("midadd_busy", busy, 32'h0);
    chk("midadd_xl", xl, 32'h0);
    chk("midadd_ov", ov, 32'h0);
    tick(1);
    resetN = 1'b1;
    tick(1);
    pulse(1); tick(8);
    chk("postrst_score", score, 32'h000050);
    chk("postrst_busy", busy, 32'h0);

    // New-game clear with an input still held high.
    resetN = 1'b0; tick(1); resetN = 1'b1; tick(1);
    pts[15:0] = 16'h1230;
    evt[0] = 1'b1; tick(1); tick(8);
    chk("held_score", score, 32'h001230);
    clr = 1'b1; tick(1); clr = 1'b0;
    chk("held_clr_score", score, 32'h0);
    chk("held_clr_hi", hiscore, 32'h001230);
    chk("held_clr_busy", busy, 32'h0);
    tick(10);
    chk("held_no_recount", score, 32'h0);
    chk("held_no_busy", busy, 32'h0);
    evt[0] = 1'b0; tick(1);
    evt[0] = 1'b1; tick(1); tick(8);
    evt[0] = 1'b0;
    chk("held_rerise", score, 32'h001230);

    // Overflow: saturating vs wrapping.
    pts2 = 24'h999990;
    evt2 = 1'b1; tick(1); evt2 = 1'b0; tick(8);
    chk("ovf_pre_sat", s_sc, 32'h999990);
    chk("ovf_pre_wrap", w_sc, 32'h999990);
    chk("ovf_pre_flag", s_ov, 32'h0);
    pts2 = 24'h000050;
    evt2 = 1'b1; tick(1); evt2 = 1'b0; tick(8);
    chk("ovf_sat_score", s_sc, 32'h999999);
    chk("ovf_sat_flag", s_ov, 32'h1);
    chk("ovf_sat_hi", s_hi, 32'h999999);
    chk("ovf_wrap_score", w_sc, 32'h000040);
    chk("ovf_wrap_flag", w_ov, 32'h1);
    chk("ovf_wrap_hi", w_hi, 32'h999990);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_score_accumulator.md
BCD_SCORE_ACCUMULATOR -- requirements
Module: bcd_score_accumulator

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 6, meaning number of BCD score digits (legal 2..8).
REQ-002 SHALL have parameter NUM_EVENTS, default 6, meaning number of scoring event channels (legal 1..16).
REQ-003 SHALL have parameter VAL_DIGITS, default 4, meaning BCD digits per event point value (legal 1..NUM_DIGITS).
REQ-004 SHALL have parameter SATURATE, default 1, meaning 1 = clamp at all-9s on overflow, 0 = wrap modulo 10^NUM_DIGITS.
REQ-005 SHALL have parameter LIFE_DIGIT, default 4, meaning extra life is awarded when score first reaches 10^LIFE_DIGIT (legal 1..NUM_DIGITS-1).
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-007 SHALL have port resetN, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port evt_level, input, NUM_EVENTS bits: level event requests; one event per rising edge per channel.
REQ-009 SHALL have port points_bcd, input, NUM_EVENTS*VAL_DIGITS*4 bits: per-channel BCD point value; channel k occupies slice k, digit 0 is the LSB nibble.
REQ-010 SHALL have port clear_score, input, 1 bit: synchronous new-game clear.
REQ-011 SHALL have port score_bcd, output, NUM_DIGITS*4 bits: current score; digit 0 is the LSB nibble.
REQ-012 SHALL have port hiscore_bcd, output, NUM_DIGITS*4 bits: highest final score since reset.
REQ-013 SHALL have port busy, output, 1 bit: high when FSM is not IDLE or any pending bit is set.
REQ-014 SHALL have port extra_life, output, 1 bit: single-cycle award pulse.
REQ-015 SHALL have port overflow, output, 1 bit: sticky flag set on score overflow.

Function
REQ-016 SHALL detect a rising edge per channel as evt_level[k] high while its one-cycle-delayed copy is low, and SHALL set pending[k] at that clock edge.
REQ-017 SHALL, in IDLE with any pending bit set, select the lowest set index, capture its points_bcd slice, clear that pending bit and enter ADD with digit index 0.
REQ-018 SHALL keep pending[k] set if a new rising edge on k coincides with its selection; no event is lost.
REQ-019 SHALL NOT count a second edge on a channel that is already pending; it merges into the one pending event.
REQ-020 SHALL, in ADD, process one digit per cycle from LSD to MSD: sum = score digit + value digit + carry; if sum > 9, write sum-10 and carry 1, else write sum and carry 0.
REQ-021 SHALL use value digits at index >= VAL_DIGITS as 0 and SHALL clamp captured value digits above 9 to 9.
REQ-022 SHALL enter FIN after digit NUM_DIGITS-1; FIN SHALL last one cycle and then return to IDLE.
REQ-023 SHALL, in FIN with final carry 1, set overflow and, if SATURATE=1, write all digits to 9; otherwise the wrapped score stands.
REQ-024 SHALL, in FIN, copy score to hiscore_bcd when the final score is greater than hiscore_bcd (BCD magnitude compare).
REQ-025 SHALL, in FIN, pulse extra_life for exactly one cycle when the armed flag is set and any score digit at index >= LIFE_DIGIT is nonzero, and SHALL then clear the armed flag.
REQ-026 SHALL give event-to-final-score latency of NUM_DIGITS+2 cycles from the edge that sets pending; score_bcd is only guaranteed coherent while the FSM is IDLE.
REQ-027 SHALL have clear_score override all other actions: score=0, pending=0, FSM=IDLE, overflow=0, armed=1, extra_life=0; hiscore_bcd and the edge-delay registers are retained.
REQ-028 SHALL NOT count, after clear_score, an event input that is still held high until it has gone low and risen again.

Reset
REQ-029 SHALL, on resetN low, asynchronously clear score, hiscore, pending, edge-delay registers, overflow, extra_life and busy, set armed=1, and set FSM=IDLE.
REQ-030 SHALL, on reset mid-ADD, abandon the in-flight addition with no partial value visible after release.

Verification
REQ-031 SHALL pass: defaults, channel 0 value 0010 pulsed once -> score 000010 after 8 cycles; busy high for those 8 cycles.
REQ-032 SHALL pass: channels 0 (0010), 1 (0050) and 2 (0200) rising in the same cycle -> three sequential adds in order 0,1,2, final score 000260, no event lost.
REQ-033 SHALL pass: score 009990, add 0010 -> score 010000 with extra_life pulse of 1 cycle; a further add of 0010 -> 010010 with no second pulse.
REQ-034 SHALL pass: score 999990, add 0050 -> SATURATE=1 gives 999999 with overflow=1; SATURATE=0 gives 000040 with overflow=1.
REQ-035 SHALL pass: score 001230 (hiscore 000000), clear_score -> score 000000, hiscore 001230, held evt_level not recounted until it re-rises.
REQ-036 SHALL pass: resetN asserted during the ADD of digit 2 -> all outputs 0 immediately, then a clean add after release.
